vga_stream_scanout: RTL and testbench

// Parametrised successor of the fixed 640x480 VGA stream sink. Accepts an Avalon-ST

---
 rtl/vga_stream_scanout.sv | 151 +++++++++++++++
 tb/tb_vga_stream_scanout.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_scanout.sv
// vga_stream_scanout: Avalon-ST video sink that buffers pixels in a FIFO and drives VGA pins
// from programmable timing counters, resyncing on startofpacket and blanking on stream faults.
module vga_stream_scanout #(
    parameter int   COLOR_BITS = 10,
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter int   FIFO_DEPTH = 8,
    parameter logic SYNC_POL   = 1'b0
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [3*COLOR_BITS-1:0] vga_stream_sync_data,
    input  logic                    vga_stream_sync_startofpacket,
    input  logic                    vga_stream_sync_endofpacket,
    input  logic                    vga_stream_sync_valid,
    output logic                    vga_stream_sync_ready,
    output logic [COLOR_BITS-1:0]   vga_r,
    output logic [COLOR_BITS-1:0]   vga_g,
    output logic [COLOR_BITS-1:0]   vga_b,
    output logic                    vga_hs,
    output logic                    vga_vs,
    output logic                    vga_blank_n,
    output logic                    underflow,
    output logic                    frame_err,
    input  logic                    clear_flags
);
    localparam int DW      = 3 * COLOR_BITS;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_END  = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_ON  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_OFF = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_END  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] VS_ON  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_OFF = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [AW:0]   FULL   = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {SEEK, WAIT, STREAM} state_t;

    state_t          state, state_n;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic [DW+1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr, rd_nxt;
    logic [AW:0]     count, count_n;
    logic [DW-1:0]   head_data;
    logic            push, pop, empty, head_sop, head_eop, next_sop;
    logic            active, origin, last, stream, black, uf, fe, in_hs, in_vs;

    assign push     = vga_stream_sync_valid & vga_stream_sync_ready;
    assign empty    = count == '0;
    assign rd_nxt   = rd_ptr + AW'(1);
    assign {head_sop, head_eop, head_data} = mem[rd_ptr];
    assign next_sop = count > (AW+1)'(1) && mem[rd_nxt][DW+1];
    assign count_n  = count + (AW+1)'(push) - (AW+1)'(pop);
    assign active   = h_cnt < H_ACT && v_cnt < V_ACT;
    assign origin   = h_cnt == '0 && v_cnt == '0;
    assign last     = h_cnt == H_END && v_cnt == V_END;
    assign in_hs    = h_cnt >= HS_ON && h_cnt < HS_OFF;
    assign in_vs    = v_cnt >= VS_ON && v_cnt < VS_OFF;
    // WAIT already streams the origin pixel so pixel (0,0) is not lost to the state change
    assign stream   = active && (state == STREAM || (state == WAIT && origin));

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        black   = 1'b1;
        uf      = 1'b0;
        fe      = 1'b0;
        if (state == SEEK && !empty) begin
            pop     = !head_sop;
            state_n = head_sop ? WAIT : SEEK;
        end
        if (stream) begin
            state_n = STREAM;
            if (empty) begin
                uf      = 1'b1;
                state_n = SEEK;
            end else if (head_sop && !origin) begin
                fe      = 1'b1;
                state_n = WAIT;
            end else begin
                pop = 1'b1;
                if (head_eop && !last) begin
                    fe      = 1'b1;
                    state_n = SEEK;
                end else if (last) begin
                    fe      = !head_eop;
                    black   = !head_eop;
                    state_n = head_eop && next_sop ? WAIT : SEEK;
                end else begin
                    black = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (push)
            mem[wr_ptr] <= {vga_stream_sync_startofpacket, vga_stream_sync_endofpacket, vga_stream_sync_data};
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            h_cnt                 <= '0;
            v_cnt                 <= '0;
            state                 <= SEEK;
            rd_ptr                <= '0;
            wr_ptr                <= '0;
            count                 <= '0;
            vga_stream_sync_ready <= 1'b0;
            vga_r                 <= '0;
            vga_g                 <= '0;
            vga_b                 <= '0;
            vga_blank_n           <= 1'b0;
            vga_hs                <= ~SYNC_POL;
            vga_vs                <= ~SYNC_POL;
            underflow             <= 1'b0;
            frame_err             <= 1'b0;
        end else begin
            h_cnt                 <= h_cnt == H_LAST ? '0 : h_cnt + HW'(1);
            v_cnt                 <= h_cnt != H_LAST ? v_cnt : v_cnt == V_LAST ? '0 : v_cnt + VW'(1);
            state                 <= state_n;
            rd_ptr                <= rd_ptr + AW'(pop);
            wr_ptr                <= wr_ptr + AW'(push);
            count                 <= count_n;
            vga_stream_sync_ready <= count_n != FULL;
            vga_r                 <= black ? '0 : head_data[3*COLOR_BITS-1:2*COLOR_BITS];
            vga_g                 <= black ? '0 : head_data[2*COLOR_BITS-1:COLOR_BITS];
            vga_b                 <= black ? '0 : head_data[COLOR_BITS-1:0];
            vga_blank_n           <= active;
            vga_hs                <= in_hs ^ ~SYNC_POL;
            vga_vs                <= in_vs ^ ~SYNC_POL;
            underflow             <= uf | (underflow & ~clear_flags);
            frame_err             <= fe | (frame_err & ~clear_flags);
        end
    end
endmodule

// File: tb/tb_vga_stream_scanout.sv
// tb_vga_stream_scanout: directed checks of raster timing, stream resync and fault handling
// on a tiny 14x7 raster with a 4-entry FIFO.
module tb_vga_stream_scanout;
    logic        clk = 1'b0;
    logic        reset_reset, clear_flags;
    logic [11:0] data;
    logic        sop, eop, valid, ready;
    logic [3:0]  r, g, b;
    logic        hs, vs, blank_n, underflow, frame_err;
    int          checks = 0, errors = 0, cyc = 0, accepted = 0, acc0;
    logic        acc;
    logic [13:0] q[$];
    logic [11:0] exp_pix [32];

    always #5 clk = ~clk;

    vga_stream_scanout #(
        .COLOR_BITS(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .FIFO_DEPTH(4), .SYNC_POL(1'b0)
    ) dut (
        .clk_clk(clk),
        .reset_reset(reset_reset),
        .vga_stream_sync_data(data),
        .vga_stream_sync_startofpacket(sop),
        .vga_stream_sync_endofpacket(eop),
        .vga_stream_sync_valid(valid),
        .vga_stream_sync_ready(ready),
        .vga_r(r),
        .vga_g(g),
        .vga_b(b),
        .vga_hs(hs),
        .vga_vs(vs),
        .vga_blank_n(blank_n),
        .underflow(underflow),
        .frame_err(frame_err),
        .clear_flags(clear_flags)
    );

    // Cycle index since the last reset edge; pins at cycle n show the counter value n-1.
    always @(posedge clk) cyc <= reset_reset ? 0 : cyc + 1;

    // Source: presents the queue head and retires it once the handshake completes.
    initial begin
        valid = 1'b0; sop = 1'b0; eop = 1'b0; data = '0;
        forever begin
            @(negedge clk);
            acc = valid && ready;
            @(posedge clk);
            if (acc) begin
                void'(q.pop_front());
                accepted++;
            end
            #2;
            valid = q.size() > 0;
            if (valid) {sop, eop, data} = q[0];
            else {sop, eop, data} = '0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [11:0] pix(input int p);
        return {4'(p), 4'(p >> 4), 4'(~p)};
    endfunction

    function automatic void set_exp(input int cut);
        for (int p = 0; p < 32; p++) exp_pix[p] = p < cut ? pix(p) : 12'd0;
    endfunction

    task automatic send(input int n, input int eop_at);
        for (int p = 0; p < n; p++) q.push_back({p == 0, p == eop_at, pix(p)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic wait_cyc(input int t);
        chk("schedule", 32'(cyc <= t), 32'd1);
        while (cyc < t) step();
    endtask

    task automatic check_range(input int f, input int c0, input int c1);
        for (int c = c0; c < c1; c++) begin
            int   h, v;
            logic act;
            h   = c % 14;
            v   = c / 14;
            act = h < 8 && v < 4;
            wait_cyc(f * 98 + c + 1);
            chk("rgb", {20'd0, r, g, b}, act ? 32'(exp_pix[v * 8 + h]) : 32'd0);
            chk("blank_n", 32'(blank_n), 32'(act));
            chk("hs", 32'(hs), 32'(!(h == 10 || h == 11)));
            chk("vs", 32'(vs), 32'(v != 5));
        end
    endtask

    task automatic check_reset_state();
        chk("rst_rgb", {20'd0, r, g, b}, 32'd0);
        chk("rst_blank_n", 32'(blank_n), 32'd0);
        chk("rst_hs", 32'(hs), 32'd1);
        chk("rst_vs", 32'(vs), 32'd1);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
    endtask

    initial begin
        reset_reset = 1'b1;
        clear_flags = 1'b0;
        step();
        step();
        reset_reset = 1'b0;
        check_reset_state();
        send(32, 31);
        send(32, 31);
        send(5, -1);
        set_exp(0);
        check_range(0, 0, 98);
        set_exp(32);
        check_range(1, 0, 98);
        check_range(2, 0, 98);
        chk("clean_underflow", 32'(underflow), 32'd0);
        chk("clean_frame_err", 32'(frame_err), 32'd0);
        // Frame 3 starves after pixel 4; refill only once pixel 5 has been needed.
        set_exp(5);
        check_range(3, 0, 8);
        send(32, 31);
        send(21, 20);
        send(32, 31);
        send(32, 31);
        check_range(3, 8, 98);
        chk("uf_set", 32'(underflow), 32'd1);
        chk("uf_no_frame_err", 32'(frame_err), 32'd0);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("uf_cleared", 32'(underflow), 32'd0);
        set_exp(32);
        check_range(4, 0, 98);
        // Short frame: EOP on pixel 20; clear_flags coincides with the error.
        set_exp(20);
        check_range(5, 0, 32);
        chk("fe_before", 32'(frame_err), 32'd0);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        chk("fe_beats_clear", 32'(frame_err), 32'd1);
        check_range(5, 32, 98);
        set_exp(32);
        check_range(6, 0, 98);
        chk("fe_sticky", 32'(frame_err), 32'd1);
        chk("fe_no_uf", 32'(underflow), 32'd0);
        // Reset in the middle of line 2 of frame 7.
        check_range(7, 0, 32);
        q.delete();
        reset_reset = 1'b1;
        step();
        reset_reset = 1'b0;
        check_reset_state();
        q.push_back({2'b00, 12'hFF0});
        q.push_back({2'b00, 12'hFF1});
        q.push_back({2'b00, 12'hFF2});
        send(32, 31);
        wait_cyc(1);
        chk("ready_after_reset", 32'(ready), 32'd1);
        set_exp(0);
        check_range(0, 0, 98);
        set_exp(32);
        check_range(1, 0, 58);
        // Vertical blank: the sink must stop after exactly FIFO_DEPTH beats.
        acc0 = accepted;
        send(32, 31);
        check_range(1, 58, 80);
        chk("vblank_accepted", 32'(accepted - acc0), 32'd4);
        chk("vblank_ready", 32'(ready), 32'd0);
        chk("vblank_valid", 32'(valid), 32'd1);
        check_range(1, 80, 98);
        check_range(2, 0, 98);
        chk("final_underflow", 32'(underflow), 32'd0);
        chk("final_frame_err", 32'(frame_err), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
